// File: rtl/dma_priority_arbiter_if.sv
// Pin bundle between the DMA request/command side and the channel arbiter.
// The arbiter uses the slave modport; the sequencing/CPU side uses master.
interface dma_priority_arbiter_if;
  logic [3:0] dreq;
  logic [3:0] mask;
  logic [3:0] sw_req;
  logic       cmd_disable;
  logic       rot_prio;
  logic       dreq_sense_low;
  logic       dack_sense_high;
  logic       hlda;
  logic       xfer_done;
  logic       hrq;
  logic [3:0] dack;
  logic       grant_vld;
  logic [1:0] grant_ch;
  logic       abort;

  modport slave (
    input  dreq, mask, sw_req, cmd_disable, rot_prio, dreq_sense_low,
           dack_sense_high, hlda, xfer_done,
    output hrq, dack, grant_vld, grant_ch, abort
  );

  modport master (
    output dreq, mask, sw_req, cmd_disable, rot_prio, dreq_sense_low,
           dack_sense_high, hlda, xfer_done,
    input  hrq, dack, grant_vld, grant_ch, abort
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter with fixed/rotating priority and the
// HRQ/HLDA hold handshake that gates the per-channel DACK lines.
//
// state     | meaning
// S_IDLE    | bus not requested; waits for an enabled request
// S_REQ     | HRQ raised, waiting for HLDA
// S_GRANT   | channel granted, DACK active until XFER_DONE or HLDA loss
// S_RELEASE | HRQ dropped, waiting for the CPU to release HLDA
module dma_priority_arbiter (
  input  logic                          clk,
  input  logic                          rst_n,
  dma_priority_arbiter_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] hp;
  logic [3:0] onehot;
  logic [3:0] req;
  logic [1:0] hp_eff;
  logic [1:0] idx;
  logic [1:0] winner;

  assign req = ((bus.dreq ^ {4{bus.dreq_sense_low}}) & ~bus.mask) | bus.sw_req;

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    hp_eff = bus.rot_prio ? hp : 2'd0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = hp_eff + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.hrq       <= 1'b0;
      onehot        <= 4'd0;
      bus.grant_vld <= 1'b0;
      bus.grant_ch  <= 2'd0;
      bus.abort     <= 1'b0;
      hp            <= 2'd0;
    end else begin
      bus.abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((|req) && !bus.cmd_disable) begin
            state   <= S_REQ;
            bus.hrq <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.hlda) begin
            if (|req) begin
              state         <= S_GRANT;
              bus.grant_ch  <= winner;
              bus.grant_vld <= 1'b1;
              onehot        <= 4'b0001 << winner;
            end else begin
              state   <= S_RELEASE;
              bus.hrq <= 1'b0;
            end
          end
        end
        S_GRANT: begin
          // Losing the bus outranks a completion in the same cycle.
          if (!bus.hlda) begin
            state         <= S_IDLE;
            bus.abort     <= 1'b1;
            bus.hrq       <= 1'b0;
            bus.grant_vld <= 1'b0;
            onehot        <= 4'd0;
          end else if (bus.xfer_done) begin
            state         <= S_RELEASE;
            bus.hrq       <= 1'b0;
            bus.grant_vld <= 1'b0;
            onehot        <= 4'd0;
            if (bus.rot_prio) hp <= bus.grant_ch + 2'd1;
          end
        end
        S_RELEASE: begin
          if (!bus.hlda) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dack = (onehot & {4{bus.dack_sense_high}}) |
                    (~onehot & {4{~bus.dack_sense_high}});

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Channel request arbiter and bus-handshake sequencer for the 8237A-style DMA controller. It combines the four hardware DREQ lines with the software request and mask registers and picks one channel under fixed or rotating priority. It runs the HRQ/HLDA hold handshake with the CPU and drives the per-channel DACK lines. It sits between the `dma_if` pins and the timing/control block, which performs the transfer and reports its completion back through `XFER_DONE`.

## Interface
- Parameters: none; the channel count is fixed at 4.
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- DREQ  in  4  hardware channel requests; active level set by DREQ_SENSE_LOW.
- MASK  in  4  mask register; 1 blocks the hardware DREQ of that channel.
- SW_REQ  in  4  software request register; not affected by MASK.
- CMD_DISABLE  in  1  command register bit 2; 1 blocks new arbitration.
- ROT_PRIO  in  1  command register bit 4; 0 selects fixed priority, 1 selects rotating priority.
- DREQ_SENSE_LOW  in  1  command register bit 6; 1 means DREQ is active-low.
- DACK_SENSE_HIGH  in  1  command register bit 7; 1 means DACK is active-high.
- HLDA  in  1  hold acknowledge from the CPU.
- XFER_DONE  in  1  one-cycle pulse from timing/control: service of the granted channel is finished.
- HRQ  out  1  hold request to the CPU (registered).
- DACK  out  4  channel acknowledges, polarity applied.
- GRANT_VLD  out  1  a channel is granted (state GRANT).
- GRANT_CH  out  2  index of the granted channel; holds its last value when GRANT_VLD=0.
- ABORT  out  1  one-cycle pulse when HLDA is lost during GRANT.

## Operation
- Effective request: `req[i] = ((DREQ[i] ^ DREQ_SENSE_LOW) & ~MASK[i]) | SW_REQ[i]`.
- Priority pointer `hp` (2 bits, reset 0) names the highest-priority channel.
- Priority order is hp, hp+1, hp+2, hp+3, all mod 4.
- When ROT_PRIO=0, `hp` is treated as 0 regardless of its stored value, giving fixed order 0 > 1 > 2 > 3.
- States:
  - IDLE → REQ when any req bit is set and CMD_DISABLE=0. HRQ goes to 1.
  - REQ: HRQ held at 1.
    - On HLDA=1 with any req bit set: latch the winner into GRANT_CH and go to GRANT.
    - On HLDA=1 with no req bit set (request withdrawn): go to RELEASE with no DACK.
  - GRANT: DACK[GRANT_CH] active, GRANT_VLD=1.
    - On XFER_DONE: go to RELEASE, drop HRQ and DACK. If ROT_PRIO=1, set `hp` to GRANT_CH+1 (mod 4).
    - On HLDA=0: go to IDLE, pulse ABORT, drop HRQ and DACK, leave `hp` unchanged.
    - HLDA=0 takes precedence over a simultaneous XFER_DONE.
  - RELEASE: HRQ=0. Go to IDLE once HLDA=0. A new HRQ is never raised before the CPU has released the bus.
- CMD_DISABLE is checked only in IDLE. An arbitration or grant already in progress runs to completion.
- Req bits changing in GRANT have no effect until the next pass through IDLE. The grant is never preempted.
- DACK drive: `DACK = onehot & {4{DACK_SENSE_HIGH}} | ~onehot & {4{~DACK_SENSE_HIGH}}`.
  - `onehot` is the registered one-hot grant vector; it is 0 outside GRANT.
  - DACK follows DACK_SENSE_HIGH combinationally.
- Reset (asynchronous, RESET=0):
  - State IDLE, HRQ=0, onehot=0, GRANT_VLD=0, GRANT_CH=0, ABORT=0, `hp`=0.
  - DACK=4'hF if DACK_SENSE_HIGH=0; DACK=4'h0 if DACK_SENSE_HIGH=1.
  - Reset mid-grant drops HRQ and DACK immediately, without waiting for a clock edge.

## Timing
- Request to HRQ: req sampled set at edge N (IDLE) → HRQ=1 after edge N.
- HLDA to DACK: HLDA sampled 1 at edge M (REQ) → DACK, GRANT_VLD and GRANT_CH valid after edge M.
- Release: XFER_DONE sampled at edge K → HRQ=0, DACK inactive and `hp` updated after edge K.
- Minimum re-arbitration: with HLDA falling one cycle after HRQ drops, a new HRQ can rise 2 cycles after that edge (RELEASE → IDLE → REQ).
- ABORT is high for exactly the one cycle after the edge that samples HLDA=0 in GRANT.

## Test plan
- Fixed priority: ROT_PRIO=0, DREQ=4'b1010 active-high, HLDA returned 2 cycles after HRQ → GRANT_CH=1, DACK=4'b1101; after XFER_DONE and a second arbitration → GRANT_CH=1 again.
- Rotating priority: ROT_PRIO=1, DREQ=4'b1111 held, four back-to-back services → GRANT_CH sequence 0, 1, 2, 3, then 0; `hp`=1 after the first service.
- Masking and software request: MASK=4'hF, DREQ=4'hF → HRQ stays 0; SW_REQ=4'b0100 → HRQ=1, GRANT_CH=2.
- Polarity: DREQ_SENSE_LOW=1 with DREQ[3]=0 and others 1, plus DACK_SENSE_HIGH=1 → GRANT_CH=3, DACK=4'b1000; idle DACK=4'h0.
- HLDA lost: drop HLDA in GRANT in the same cycle as XFER_DONE → ABORT pulses, HRQ=0, DACK inactive, `hp` unchanged.
- Disable and reset: CMD_DISABLE=1 in IDLE with DREQ active → no HRQ. Assert RESET during GRANT → HRQ=0 and DACK inactive before the next CLK edge, all outputs at reset values.
